// File: rtl/asymmetric_tdp_ram_modes_if.sv
`default_nettype none
// ============================================================================
// Module   : asymmetric_tdp_ram_modes_if
// Brief    : Port bundle for the asymmetric true-dual-port RAM. Carries both
//            access ports plus the read-side outputs and the collision strobe.
// Revision : 1.0 - initial release
// ============================================================================
interface asymmetric_tdp_ram_modes_if #(
  parameter int WIDTHA     = 8,
  parameter int ADDRWIDTHA = 8,
  parameter int WIDTHB     = 32,
  parameter int ADDRWIDTHB = 6
);
  localparam int MINWIDTH = (WIDTHA < WIDTHB) ? WIDTHA : WIDTHB;
  localparam int LANESA   = WIDTHA / MINWIDTH;
  localparam int LANESB   = WIDTHB / MINWIDTH;

  logic                  enA;
  logic [LANESA-1:0]     weA;
  logic [ADDRWIDTHA-1:0] addrA;
  logic [WIDTHA-1:0]     diA;
  logic [WIDTHA-1:0]     doA;
  logic                  vldA;

  logic                  enB;
  logic [LANESB-1:0]     weB;
  logic [ADDRWIDTHB-1:0] addrB;
  logic [WIDTHB-1:0]     diB;
  logic [WIDTHB-1:0]     doB;
  logic                  vldB;

  logic                  collision;

  modport master (
    output enA, weA, addrA, diA,
    output enB, weB, addrB, diB,
    input  doA, vldA, doB, vldB, collision
  );

  modport slave (
    input  enA, weA, addrA, diA,
    input  enB, weB, addrB, diB,
    output doA, vldA, doB, vldB, collision
  );
endinterface
`default_nettype wire

// File: rtl/asymmetric_tdp_ram_modes.sv
`default_nettype none
// ============================================================================
// Module   : asymmetric_tdp_ram_modes
// Brief    : Single-clock true-dual-port RAM with ports of different widths.
//            Storage is kept at the narrow width; a wide port touches RATIO
//            consecutive narrow words, lane 0 in the LSBs. Each port has its
//            own read-during-write mode, per-lane write enables, optional
//            output register and a valid strobe. A collision strobe flags
//            same-cycle cross-port conflicts, aligned with the read data.
// Revision : 1.0 - initial release
// ============================================================================
module asymmetric_tdp_ram_modes #(
  parameter int WIDTHA     = 8,
  parameter int SIZEA      = 256,
  parameter int ADDRWIDTHA = 8,
  parameter int WIDTHB     = 32,
  parameter int SIZEB      = 64,
  parameter int ADDRWIDTHB = 6,
  parameter int MODEA      = 0,
  parameter int MODEB      = 0,
  parameter int OUTREG     = 0
) (
  input logic                        clk,
  input logic                        rst_n,
  asymmetric_tdp_ram_modes_if.slave  bus
);

  localparam int MINWIDTH = (WIDTHA < WIDTHB) ? WIDTHA : WIDTHB;
  localparam int MAXSIZE  = (SIZEA > SIZEB) ? SIZEA : SIZEB;
  localparam int LANESA   = WIDTHA / MINWIDTH;
  localparam int LANESB   = WIDTHB / MINWIDTH;
  localparam int IDXW     = (MAXSIZE > 1) ? $clog2(MAXSIZE) : 1;

  typedef logic [IDXW-1:0] idx_t;

  logic [MINWIDTH-1:0]   mem [MAXSIZE];

  logic [ADDRWIDTHA-1:0] w_addrA;
  logic [ADDRWIDTHB-1:0] w_addrB;
  idx_t                  w_idxA [LANESA];
  idx_t                  w_idxB [LANESB];
  logic [WIDTHA-1:0]     w_rdA;
  logic [WIDTHB-1:0]     w_rdB;
  logic                  w_wrEnA;
  logic                  w_wrEnB;
  logic                  w_coll;

  logic [WIDTHA-1:0]     r_doA1;
  logic                  r_vldA1;
  logic [WIDTHB-1:0]     r_doB1;
  logic                  r_vldB1;
  logic                  r_coll1;

  assign w_addrA = bus.addrA;
  assign w_addrB = bus.addrB;

  // Writes are blocked while reset is held; contents themselves are never cleared.
  assign w_wrEnA = bus.enA & rst_n;
  assign w_wrEnB = bus.enB & rst_n;

  // Map each lane of each port onto its narrow-word index.
  always_comb begin
    for (int i = 0; i < LANESA; i++) begin
      w_idxA[i] = idx_t'(w_addrA) * idx_t'(LANESA) + idx_t'(i);
    end
    for (int j = 0; j < LANESB; j++) begin
      w_idxB[j] = idx_t'(w_addrB) * idx_t'(LANESB) + idx_t'(j);
    end
  end

  // Own-port read data: write-first forwards written lanes, all else is the stored (pre-write) word.
  always_comb begin
    w_rdA = '0;
    w_rdB = '0;
    for (int i = 0; i < LANESA; i++) begin
      w_rdA[i*MINWIDTH +: MINWIDTH] = (MODEA == 0 && bus.weA[i]) ?
                                      bus.diA[i*MINWIDTH +: MINWIDTH] : mem[w_idxA[i]];
    end
    for (int j = 0; j < LANESB; j++) begin
      w_rdB[j*MINWIDTH +: MINWIDTH] = (MODEB == 0 && bus.weB[j]) ?
                                      bus.diB[j*MINWIDTH +: MINWIDTH] : mem[w_idxB[j]];
    end
  end

  // Conflict: both enabled, a shared narrow word, and either port writes that word.
  always_comb begin
    w_coll = 1'b0;
    for (int i = 0; i < LANESA; i++) begin
      for (int j = 0; j < LANESB; j++) begin
        if ((w_idxA[i] == w_idxB[j]) && (bus.weA[i] || bus.weB[j])) begin
          w_coll = 1'b1;
        end
      end
    end
    w_coll = w_coll & bus.enA & bus.enB;
  end

  // Storage update; port A is written last so it wins a same-lane tie.
  always_ff @(posedge clk) begin
    for (int j = 0; j < LANESB; j++) begin
      if (w_wrEnB && bus.weB[j]) begin
        mem[w_idxB[j]] <= bus.diB[j*MINWIDTH +: MINWIDTH];
      end
    end
    for (int i = 0; i < LANESA; i++) begin
      if (w_wrEnA && bus.weA[i]) begin
        mem[w_idxA[i]] <= bus.diA[i*MINWIDTH +: MINWIDTH];
      end
    end
  end

  // Port A first output stage; no-change mode holds data and drops valid on a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_doA1  <= '0;
      r_vldA1 <= 1'b0;
    end else if (bus.enA) begin
      if (MODEA == 2 && |bus.weA) begin
        r_vldA1 <= 1'b0;
      end else begin
        r_doA1  <= w_rdA;
        r_vldA1 <= 1'b1;
      end
    end else begin
      r_vldA1 <= 1'b0;
    end
  end

  // Port B first output stage, same behaviour as port A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_doB1  <= '0;
      r_vldB1 <= 1'b0;
    end else if (bus.enB) begin
      if (MODEB == 2 && |bus.weB) begin
        r_vldB1 <= 1'b0;
      end else begin
        r_doB1  <= w_rdB;
        r_vldB1 <= 1'b1;
      end
    end else begin
      r_vldB1 <= 1'b0;
    end
  end

  // Collision strobe registered so it lines up with the first-stage valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coll1 <= 1'b0;
    end else begin
      r_coll1 <= w_coll;
    end
  end

  generate
    if (OUTREG == 1) begin : g_outreg
      logic [WIDTHA-1:0] r_doA2;
      logic              r_vldA2;
      logic [WIDTHB-1:0] r_doB2;
      logic              r_vldB2;
      logic              r_coll2;

      // Second stage advances every cycle, carrying data, valid and collision together.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_doA2  <= '0;
          r_vldA2 <= 1'b0;
          r_doB2  <= '0;
          r_vldB2 <= 1'b0;
          r_coll2 <= 1'b0;
        end else begin
          r_doA2  <= r_doA1;
          r_vldA2 <= r_vldA1;
          r_doB2  <= r_doB1;
          r_vldB2 <= r_vldB1;
          r_coll2 <= r_coll1;
        end
      end

      assign bus.doA       = r_doA2;
      assign bus.vldA      = r_vldA2;
      assign bus.doB       = r_doB2;
      assign bus.vldB      = r_vldB2;
      assign bus.collision = r_coll2;
    end else begin : g_noreg
      assign bus.doA       = r_doA1;
      assign bus.vldA      = r_vldA1;
      assign bus.doB       = r_doB1;
      assign bus.vldB      = r_vldB1;
      assign bus.collision = r_coll1;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_asymmetric_tdp_ram_modes.sv
`default_nettype none
// ============================================================================
// Module   : tb_asymmetric_tdp_ram_modes
// Brief    : Directed bench for the asymmetric TDP RAM. Four instances share
//            one stimulus stream: dut0 write-first/latency 1, dut1 port A
//            read-first, dut2 port A no-change, dut3 output register enabled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_asymmetric_tdp_ram_modes;

  logic        clk;
  logic        rst_n;
  logic        enA;
  logic [0:0]  weA;
  logic [7:0]  addrA;
  logic [7:0]  diA;
  logic        enB;
  logic [3:0]  weB;
  logic [5:0]  addrB;
  logic [31:0] diB;

  logic [7:0]  doA  [4];
  logic        vldA [4];
  logic [31:0] doB  [4];
  logic        vldB [4];
  logic        coll [4];

  int nVec;
  int nErr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    asymmetric_tdp_ram_modes_if u_if ();

    assign u_if.enA   = enA;
    assign u_if.weA   = weA;
    assign u_if.addrA = addrA;
    assign u_if.diA   = diA;
    assign u_if.enB   = enB;
    assign u_if.weB   = weB;
    assign u_if.addrB = addrB;
    assign u_if.diB   = diB;

    assign doA[k]  = u_if.doA;
    assign vldA[k] = u_if.vldA;
    assign doB[k]  = u_if.doB;
    assign vldB[k] = u_if.vldB;
    assign coll[k] = u_if.collision;

    asymmetric_tdp_ram_modes #(
      .MODEA  ((k == 1) ? 1 : ((k == 2) ? 2 : 0)),
      .OUTREG ((k == 3) ? 1 : 0)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic eA, input logic wA, input logic [7:0] aA, input logic [7:0] dA,
                       input logic eB, input logic [3:0] wB, input logic [5:0] aB, input logic [31:0] dB);
    enA = eA; weA = wA; addrA = aA; diA = dA;
    enB = eB; weB = wB; addrB = aB; diB = dB;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] streamExp [4];
    streamExp[0] = 8'h11; streamExp[1] = 8'h22; streamExp[2] = 8'h33; streamExp[3] = 8'h44;
    nVec = 0;
    nErr = 0;

    // Reset state
    rst_n = 1'b0;
    drive(0, 0, 8'd0, 8'h00, 0, 4'h0, 6'd0, 32'h0);
    tick();
    tick();
    chk("rst_doA",  {24'h0, doA[0]}, 32'h0);
    chk("rst_vldA", {31'h0, vldA[0]}, 32'h0);
    chk("rst_doB",  doB[0], 32'h0);
    chk("rst_vldB", {31'h0, vldB[0]}, 32'h0);
    chk("rst_coll", {31'h0, coll[0]}, 32'h0);
    chk("rst_doA3", {24'h0, doA[3]}, 32'h0);
    rst_n = 1'b1;

    // Port B full-word write, write-first returns the new word
    drive(0, 0, 8'd0, 8'h00, 1, 4'hF, 6'd3, 32'h44332211);
    tick();
    chk("bwr_doB",  doB[0], 32'h44332211);
    chk("bwr_vldB", {31'h0, vldB[0]}, 32'h1);

    // Port A streams narrow reads of word 3; dut3 trails by one cycle
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 8'(12 + k), 8'h00, 0, 4'h0, 6'd0, 32'h0);
      tick();
      chk("ard_doA",  {24'h0, doA[0]}, {24'h0, streamExp[k]});
      chk("ard_vldA", {31'h0, vldA[0]}, 32'h1);
      if (k == 0) begin
        chk("or_vld_lat", {31'h0, vldA[3]}, 32'h0);
      end else begin
        chk("or_doA",  {24'h0, doA[3]}, {24'h0, streamExp[k-1]});
        chk("or_vldA", {31'h0, vldA[3]}, 32'h1);
      end
    end
    drive(0, 0, 8'd0, 8'h00, 0, 4'h0, 6'd0, 32'h0);
    tick();
    chk("or_doA_last", {24'h0, doA[3]}, 32'h44);
    chk("or_vld_last", {31'h0, vldA[3]}, 32'h1);
    chk("idle_vldA",   {31'h0, vldA[0]}, 32'h0);
    tick();
    chk("or_vld_end",  {31'h0, vldA[3]}, 32'h0);

    // Lane write enable on port B
    drive(0, 0, 8'd0, 8'h00, 1, 4'b0100, 6'd3, 32'hAABBCCDD);
    tick();
    chk("lane_doB",  doB[0], 32'h44BB2211);
    chk("lane_vldB", {31'h0, vldB[0]}, 32'h1);
    chk("lane_coll", {31'h0, coll[0]}, 32'h0);
    drive(1, 0, 8'd14, 8'h00, 0, 4'h0, 6'd0, 32'h0);
    tick();
    chk("lane_doA", {24'h0, doA[0]}, 32'hBB);

    // Port A write: write-first / read-first / no-change
    drive(1, 1, 8'd12, 8'h55, 0, 4'h0, 6'd0, 32'h0);
    tick();
    chk("wf_doA",   {24'h0, doA[0]}, 32'h55);
    chk("rf_doA",   {24'h0, doA[1]}, 32'h11);
    chk("rf_vldA",  {31'h0, vldA[1]}, 32'h1);
    chk("nc_doA",   {24'h0, doA[2]}, 32'hBB);
    chk("nc_vldA",  {31'h0, vldA[2]}, 32'h0);
    drive(1, 0, 8'd12, 8'h00, 0, 4'h0, 6'd0, 32'h0);
    tick();
    chk("rf_rdback", {24'h0, doA[1]}, 32'h55);
    chk("nc_rdback", {24'h0, doA[2]}, 32'h55);
    chk("nc_vldrd",  {31'h0, vldA[2]}, 32'h1);
    drive(1, 1, 8'd12, 8'h11, 0, 4'h0, 6'd0, 32'h0);
    tick();
    chk("restore_doA", {24'h0, doA[0]}, 32'h11);

    // Cross-port: A writes a lane B is reading
    drive(1, 1, 8'd13, 8'h77, 1, 4'h0, 6'd3, 32'h0);
    tick();
    chk("xrd_doB",  doB[0], 32'h44BB2211);
    chk("xrd_vldB", {31'h0, vldB[0]}, 32'h1);
    chk("xrd_coll", {31'h0, coll[0]}, 32'h1);

    // Both ports write lane 1 of word 3; A wins
    drive(1, 1, 8'd13, 8'h99, 1, 4'b0010, 6'd3, 32'h0000EE00);
    tick();
    chk("ww_coll", {31'h0, coll[0]}, 32'h1);
    chk("ww_doB",  doB[0], 32'h44BBEE11);
    drive(0, 0, 8'd0, 8'h00, 1, 4'h0, 6'd3, 32'h0);
    tick();
    chk("ww_store", doB[0], 32'h44BB9911);
    chk("ww_coll0", {31'h0, coll[0]}, 32'h0);

    // Disjoint addresses
    drive(1, 1, 8'd0, 8'h5A, 1, 4'h0, 6'd3, 32'h0);
    tick();
    chk("dis_coll", {31'h0, coll[0]}, 32'h0);
    chk("dis_doA",  {24'h0, doA[0]}, 32'h5A);

    // Stream, then reset mid-operation
    drive(1, 0, 8'd12, 8'h00, 0, 4'h0, 6'd0, 32'h0);
    tick();
    chk("pre_doA", {24'h0, doA[0]}, 32'h11);
    drive(1, 1, 8'd0, 8'h5A, 1, 4'h0, 6'd0, 32'h0);
    tick();
    chk("pre_coll", {31'h0, coll[0]}, 32'h1);
    chk("pre_doA3", {24'h0, doA[3]}, 32'h11);
    rst_n = 1'b0;
    #1;
    chk("mr_doA",  {24'h0, doA[0]}, 32'h0);
    chk("mr_vldA", {31'h0, vldA[0]}, 32'h0);
    chk("mr_doB",  doB[0], 32'h0);
    chk("mr_vldB", {31'h0, vldB[0]}, 32'h0);
    chk("mr_coll", {31'h0, coll[0]}, 32'h0);
    chk("mr_doA3", {24'h0, doA[3]}, 32'h0);
    chk("mr_vldA3", {31'h0, vldA[3]}, 32'h0);
    drive(1, 1, 8'd12, 8'hFF, 1, 4'hF, 6'd3, 32'h00000000);
    tick();
    tick();
    chk("inr_vldA", {31'h0, vldA[0]}, 32'h0);
    chk("inr_doB",  doB[0], 32'h0);
    rst_n = 1'b1;
    drive(1, 0, 8'd12, 8'h00, 1, 4'h0, 6'd3, 32'h0);
    tick();
    chk("post_doA",  {24'h0, doA[0]}, 32'h11);
    chk("post_vldA", {31'h0, vldA[0]}, 32'h1);
    chk("post_doB",  doB[0], 32'h44BB9911);
    chk("post_coll", {31'h0, coll[0]}, 32'h0);

    drive(0, 0, 8'd0, 8'h00, 0, 4'h0, 6'd0, 32'h0);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
`default_nettype wire
